// File: rtl/prim_ram_2p_fifo_pkg.sv
// Shared constants, types and width helpers for the RAM-backed FIFO controller.
// Optional synchronous flush is enabled with PRIM_RAM_2P_FIFO_CLR_EN.
package prim_ram_2p_fifo_pkg;

    localparam int ObufDepth = 2;
    localparam int ObufCntW  = $clog2(ObufDepth + 1);

    // Occupancy of the output buffer, 0..ObufDepth.
    typedef logic [ObufCntW-1:0] obuf_cnt_t;

    // Occupancy can reach Depth words in RAM plus one in flight plus the buffer.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + ObufDepth + 1);
    endfunction

endpackage

// File: rtl/prim_ram_2p_fifo_obuf.sv
// Two-entry in-order register FIFO that absorbs the RAM read latency.
// Gains a synchronous i_clr input when PRIM_RAM_2P_FIFO_CLR_EN is defined.
module prim_ram_2p_fifo_obuf
    import prim_ram_2p_fifo_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef PRIM_RAM_2P_FIFO_CLR_EN
    input  logic             i_clr,
`endif
    input  logic             i_enq,
    input  logic             i_deq,
    input  logic [Width-1:0] i_data,
    output obuf_cnt_t        o_cnt,
    output logic [Width-1:0] o_head
);

    logic [Width-1:0] r_head;
    logic [Width-1:0] r_tail;
    obuf_cnt_t        r_cnt;

    // The head slot always holds the oldest word; the tail shifts forward on a dequeue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end
`ifdef PRIM_RAM_2P_FIFO_CLR_EN
        else if (i_clr) begin
            r_cnt <= '0;
        end
`endif
        else begin
            r_cnt <= r_cnt + obuf_cnt_t'(i_enq) - obuf_cnt_t'(i_deq);
            if (i_deq) begin
                if (r_cnt == obuf_cnt_t'(ObufDepth)) begin
                    r_head <= r_tail;
                    if (i_enq) begin
                        r_tail <= i_data;
                    end
                end else if (i_enq) begin
                    r_head <= i_data;
                end
            end else if (i_enq) begin
                if (r_cnt == '0) begin
                    r_head <= i_data;
                end else begin
                    r_tail <= i_data;
                end
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_head;

endmodule

// File: rtl/prim_ram_2p_fifo.sv
// FIFO controller driving a dual-port synchronous RAM (A write, B read) with a 2-entry output buffer.
// Define PRIM_RAM_2P_FIFO_CLR_EN to add the synchronous flush input clr_i.
module prim_ram_2p_fifo
    import prim_ram_2p_fifo_pkg::*;
#(
    parameter  int Width = 32,
    parameter  int Depth = 128,
    localparam int Aw    = $clog2(Depth),
    localparam int CntW  = calc_cnt_w(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef PRIM_RAM_2P_FIFO_CLR_EN
    input  logic             clr_i,
`endif
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  depth_o,
    output logic             full_o,
    output logic             ram_a_req_o,
    output logic             ram_a_write_o,
    output logic [Aw-1:0]    ram_a_addr_o,
    output logic [Width-1:0] ram_a_wdata_o,
    output logic [Width-1:0] ram_a_wmask_o,
    output logic             ram_b_req_o,
    output logic             ram_b_write_o,
    output logic [Aw-1:0]    ram_b_addr_o,
    input  logic [Width-1:0] ram_b_rdata_i
);

    localparam int          PendW   = ObufCntW + 1;
    localparam logic [Aw:0] RamFull = (Aw + 1)'(Depth);

    logic [Aw-1:0]    r_wptr;
    logic [Aw-1:0]    r_rptr;
    logic [Aw:0]      r_ram_cnt;
    logic             r_inflight;
    obuf_cnt_t        w_obuf_cnt;
    logic [Width-1:0] w_obuf_head;
    logic             w_wready;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [PendW-1:0] w_pending;

`ifdef PRIM_RAM_2P_FIFO_CLR_EN
    assign w_wready = (r_ram_cnt != RamFull) && !clr_i;
`else
    assign w_wready = (r_ram_cnt != RamFull);
`endif

    assign w_push   = wvalid_i && w_wready;
    assign w_pop    = rvalid_o && rready_i;

    // Words already committed to the buffer after this cycle's pop; keep it below two.
    assign w_pending = PendW'(w_obuf_cnt) + PendW'(r_inflight) - PendW'(w_pop);

`ifdef PRIM_RAM_2P_FIFO_CLR_EN
    assign w_issue = (r_ram_cnt != '0) && (w_pending < PendW'(ObufDepth)) && !clr_i;
`else
    assign w_issue = (r_ram_cnt != '0) && (w_pending < PendW'(ObufDepth));
`endif

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end
`ifdef PRIM_RAM_2P_FIFO_CLR_EN
        else if (clr_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end
`endif
        else begin
            if (w_push) begin
                r_wptr <= r_wptr + Aw'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + Aw'(1);
            end
            r_ram_cnt  <= r_ram_cnt + (Aw + 1)'(w_push) - (Aw + 1)'(w_issue);
            r_inflight <= w_issue;
        end
    end

    prim_ram_2p_fifo_obuf #(
        .Width (Width)
    ) u_obuf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
`ifdef PRIM_RAM_2P_FIFO_CLR_EN
        .i_clr  (clr_i),
`endif
        .i_enq  (r_inflight),
        .i_deq  (w_pop),
        .i_data (ram_b_rdata_i),
        .o_cnt  (w_obuf_cnt),
        .o_head (w_obuf_head)
    );

    assign wready_o      = w_wready;
    assign full_o        = !w_wready;
    assign rvalid_o      = (w_obuf_cnt != '0);
    assign rdata_o       = w_obuf_head;
    assign depth_o       = CntW'(r_ram_cnt) + CntW'(r_inflight) + CntW'(w_obuf_cnt);

    assign ram_a_req_o   = w_push;
    assign ram_a_write_o = w_push;
    assign ram_a_addr_o  = r_wptr;
    assign ram_a_wdata_o = wdata_i;
    assign ram_a_wmask_o = '1;

    assign ram_b_req_o   = w_issue;
    assign ram_b_write_o = 1'b0;
    assign ram_b_addr_o  = r_rptr;

endmodule
